// File: rtl/csr_pkg.sv
// Shared types for the CSR execution sequencer.
// Holds the op encodings, FSM states and the captured-op bundle.
package csr_pkg;

  localparam int unsigned PK_DATA_W = 32;
  localparam int unsigned PK_PREG_W = 6;
  localparam int unsigned PK_TAG_W  = 6;
  localparam int unsigned PK_CSR_AW = 14;

  localparam logic [3:0] CSRRD_CONF = 4'd1;
  localparam logic [3:0] CSRWR_CONF = 4'd2;
  localparam logic [3:0] CSRXG_CONF = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EXEC,
    S_BCAST
  } state_e;

  typedef struct packed {
    logic [PK_TAG_W-1:0]  tag;
    logic [3:0]           conf;
    logic [PK_PREG_W-1:0] pj;
    logic [PK_PREG_W-1:0] pd_old;
    logic [PK_PREG_W-1:0] pd;
    logic [PK_CSR_AW-1:0] addr;
    logic                 regwr;
    logic                 csrwr;
  } csr_op_t;

endpackage

// File: rtl/csr_alu.sv
// Computes the new CSR value for read/write/exchange ops.
// Unknown encodings behave as a plain read.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]        conf_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] rd_i,
  input  logic [DATA_W-1:0] j_i,
  output logic              wr_o,
  output logic [DATA_W-1:0] new_o,
  output logic [DATA_W-1:0] old_o
);

  // op decode and bitwise merge
  always_comb begin
    wr_o  = 1'b0;
    new_o = old_i;
    old_o = old_i;
    case (conf_i)
      CSRWR_CONF: begin
        wr_o  = 1'b1;
        new_o = rd_i;
      end
      CSRXG_CONF: begin
        wr_o  = 1'b1;
        new_o = (old_i & ~j_i) | (rd_i & j_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_exec_sequencer.sv
// One-at-a-time CSR op sequencer: PRF read, wait for ROB head,
// atomic CSR access, then broadcast the old value on CDB 4.
module csr_exec_sequencer
  import csr_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned CSR_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ready_awake,
  input  logic [TAG_W-1:0]  tag_rob_awake,
  input  logic [3:0]        Conf_awake,
  input  logic [PREG_W-1:0] Pj_awake,
  input  logic [PREG_W-1:0] Pd_old_awake,
  input  logic [PREG_W-1:0] Pd_awake,
  input  logic [CSR_AW-1:0] csr_addr_awake,
  input  logic              RegWr_awake,
  input  logic              csrWr_awake,
  output logic [PREG_W-1:0] prf_raddr_j,
  output logic [PREG_W-1:0] prf_raddr_d,
  input  logic [DATA_W-1:0] prf_rdata_j,
  input  logic [DATA_W-1:0] prf_rdata_d,
  input  logic              rob_head_valid,
  input  logic [TAG_W-1:0]  rob_head_tag,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [DATA_W-1:0] csr_rdata,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic              cdb_stall,
  output logic              ready_cdb4,
  output logic              RegWr_cdb4,
  output logic [PREG_W-1:0] Pd_cdb4,
  output logic [DATA_W-1:0] data_cdb4,
  output logic [TAG_W-1:0]  tag_rob_cdb4,
  output logic              busy,
  output logic              err_overrun
);

  state_e            state_q, state_d;
  csr_op_t           op_q, op_d;
  logic [DATA_W-1:0] j_q, j_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic              alu_wr;
  logic [DATA_W-1:0] alu_new;
  logic [DATA_W-1:0] alu_old;
  logic              in_exec;
  logic              in_bcast;

  csr_alu #(.DATA_W(DATA_W)) u_alu (
    .conf_i (op_q.conf),
    .old_i  (csr_rdata),
    .rd_i   (rd_q),
    .j_i    (j_q),
    .wr_o   (alu_wr),
    .new_o  (alu_new),
    .old_o  (alu_old)
  );

  // next-state: capture, operand read, head wait, exec, broadcast
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    j_d     = j_q;
    rd_d    = rd_q;
    res_d   = res_q;
    err_d   = err_q;
    if (ready_awake && state_q != S_IDLE)
      err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (ready_awake && !flush) begin
          op_d.tag    = tag_rob_awake;
          op_d.conf   = Conf_awake;
          op_d.pj     = Pj_awake;
          op_d.pd_old = Pd_old_awake;
          op_d.pd     = Pd_awake;
          op_d.addr   = csr_addr_awake;
          op_d.regwr  = RegWr_awake;
          op_d.csrwr  = csrWr_awake;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        j_d     = prf_rdata_j;
        rd_d    = prf_rdata_d;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rob_head_valid && rob_head_tag == op_q.tag)
          state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_old;
        state_d = S_BCAST;
      end
      S_BCAST: begin
        if (!cdb_stall)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush)
      state_d = S_IDLE;
  end

  // state and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      j_q     <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      j_q     <= j_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // outputs decoded from the current state
  always_comb begin
    in_exec      = (state_q == S_EXEC);
    in_bcast     = (state_q == S_BCAST);
    busy         = (state_q != S_IDLE);
    prf_raddr_j  = busy ? op_q.pj : '0;
    prf_raddr_d  = busy ? op_q.pd_old : '0;
    csr_raddr    = in_exec ? op_q.addr : '0;
    csr_we       = in_exec && op_q.csrwr && alu_wr && !flush;
    csr_waddr    = csr_we ? op_q.addr : '0;
    csr_wdata    = csr_we ? alu_new : '0;
    ready_cdb4   = in_bcast;
    RegWr_cdb4   = in_bcast ? op_q.regwr : 1'b0;
    Pd_cdb4      = in_bcast ? op_q.pd : '0;
    data_cdb4    = in_bcast ? res_q : '0;
    tag_rob_cdb4 = in_bcast ? op_q.tag : '0;
    err_overrun  = err_q;
  end

endmodule

// File: tb/tb_csr_exec_sequencer.sv
// Scoreboard bench for csr_exec_sequencer.
// Stimulus pushes expected CSR writes, CDB beats and status samples.
module tb_csr_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ready_awake;
  logic [5:0]  tag_rob_awake;
  logic [3:0]  Conf_awake;
  logic [5:0]  Pj_awake;
  logic [5:0]  Pd_old_awake;
  logic [5:0]  Pd_awake;
  logic [13:0] csr_addr_awake;
  logic        RegWr_awake;
  logic        csrWr_awake;
  logic [5:0]  prf_raddr_j;
  logic [5:0]  prf_raddr_d;
  logic [31:0] prf_rdata_j;
  logic [31:0] prf_rdata_d;
  logic        rob_head_valid;
  logic [5:0]  rob_head_tag;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        cdb_stall;
  logic        ready_cdb4;
  logic        RegWr_cdb4;
  logic [5:0]  Pd_cdb4;
  logic [31:0] data_cdb4;
  logic [5:0]  tag_rob_cdb4;
  logic        busy;
  logic        err_overrun;

  csr_exec_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .ready_awake    (ready_awake),
    .tag_rob_awake  (tag_rob_awake),
    .Conf_awake     (Conf_awake),
    .Pj_awake       (Pj_awake),
    .Pd_old_awake   (Pd_old_awake),
    .Pd_awake       (Pd_awake),
    .csr_addr_awake (csr_addr_awake),
    .RegWr_awake    (RegWr_awake),
    .csrWr_awake    (csrWr_awake),
    .prf_raddr_j    (prf_raddr_j),
    .prf_raddr_d    (prf_raddr_d),
    .prf_rdata_j    (prf_rdata_j),
    .prf_rdata_d    (prf_rdata_d),
    .rob_head_valid (rob_head_valid),
    .rob_head_tag   (rob_head_tag),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .cdb_stall      (cdb_stall),
    .ready_cdb4     (ready_cdb4),
    .RegWr_cdb4     (RegWr_cdb4),
    .Pd_cdb4        (Pd_cdb4),
    .data_cdb4      (data_cdb4),
    .tag_rob_cdb4   (tag_rob_cdb4),
    .busy           (busy),
    .err_overrun    (err_overrun)
  );

  localparam logic [3:0] RD = 4'd1;
  localparam logic [3:0] WR = 4'd2;
  localparam logic [3:0] XG = 4'd3;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] prf_mem [64];
  logic [31:0] csr_mem [16];
  assign prf_rdata_j = prf_mem[prf_raddr_j];
  assign prf_rdata_d = prf_mem[prf_raddr_d];
  assign csr_rdata   = csr_mem[csr_raddr[3:0]];

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          cyc;
    logic        regwr;
    logic [5:0]  pd;
    logic [31:0] data;
    logic [5:0]  tag;
  } cdb_t;

  typedef struct {
    int         cyc;
    logic       busy;
    logic       err;
    logic       cdbv;
    logic [5:0] rj;
  } st_t;

  wr_t  wq [$];
  cdb_t cq [$];
  st_t  sq [$];
  wr_t  we_e;
  cdb_t ce_e;
  st_t  st_e;

  int tests_run    = 0;
  int tests_failed = 0;
  bit done         = 1'b0;

  // monitor: compare every DUT output event against the queues
  always @(negedge clk) begin
    if (csr_we) begin
      tests_run++;
      if (wq.size() == 0) begin
        tests_failed++;
        $display("FAIL csr_write: unexpected cyc=%0d addr=%h data=%h",
                 cyc, csr_waddr, csr_wdata);
      end else begin
        we_e = wq.pop_front();
        if (we_e.cyc != cyc || we_e.addr != csr_waddr ||
            we_e.data != csr_wdata) begin
          tests_failed++;
          $display("FAIL csr_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                   cyc, csr_waddr, csr_wdata, we_e.cyc, we_e.addr, we_e.data);
        end
      end
    end
    if (ready_cdb4) begin
      tests_run++;
      if (cq.size() == 0) begin
        tests_failed++;
        $display("FAIL cdb4: unexpected cyc=%0d pd=%0d data=%h tag=%0d",
                 cyc, Pd_cdb4, data_cdb4, tag_rob_cdb4);
      end else begin
        ce_e = cq.pop_front();
        if (ce_e.cyc != cyc || ce_e.regwr != RegWr_cdb4 ||
            ce_e.pd != Pd_cdb4 || ce_e.data != data_cdb4 ||
            ce_e.tag != tag_rob_cdb4) begin
          tests_failed++;
          $display("FAIL cdb4: got cyc=%0d we=%b pd=%0d data=%h tag=%0d want cyc=%0d we=%b pd=%0d data=%h tag=%0d",
                   cyc, RegWr_cdb4, Pd_cdb4, data_cdb4, tag_rob_cdb4,
                   ce_e.cyc, ce_e.regwr, ce_e.pd, ce_e.data, ce_e.tag);
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      st_e = sq.pop_front();
      tests_run++;
      if (st_e.cyc != cyc || st_e.busy != busy || st_e.err != err_overrun ||
          st_e.cdbv != ready_cdb4 || st_e.rj != prf_raddr_j) begin
        tests_failed++;
        $display("FAIL status: got cyc=%0d busy=%b err=%b cdbv=%b rj=%0d want cyc=%0d busy=%b err=%b cdbv=%b rj=%0d",
                 cyc, busy, err_overrun, ready_cdb4, prf_raddr_j,
                 st_e.cyc, st_e.busy, st_e.err, st_e.cdbv, st_e.rj);
      end
    end
    if (done) begin
      tests_run++;
      if (wq.size() != 0 || cq.size() != 0 || sq.size() != 0) begin
        tests_failed++;
        $display("FAIL drain: pending wr=%0d cdb=%0d st=%0d want 0 0 0",
                 wq.size(), cq.size(), sq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic issue(input logic [3:0] conf, input logic [5:0] pj,
                       input logic [5:0] pdo, input logic [5:0] pd,
                       input logic [13:0] addr, input logic regwr,
                       input logic csrwr, input logic [5:0] tag,
                       output int t);
    tag_rob_awake  = tag;
    Conf_awake     = conf;
    Pj_awake       = pj;
    Pd_old_awake   = pdo;
    Pd_awake       = pd;
    csr_addr_awake = addr;
    RegWr_awake    = regwr;
    csrWr_awake    = csrwr;
    ready_awake    = 1'b1;
    t = cyc;
    tick();
    ready_awake = 1'b0;
  endtask

  int t;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ready_awake = 1'b0;
    tag_rob_awake = '0;
    Conf_awake = '0;
    Pj_awake = '0;
    Pd_old_awake = '0;
    Pd_awake = '0;
    csr_addr_awake = '0;
    RegWr_awake = 1'b0;
    csrWr_awake = 1'b0;
    rob_head_valid = 1'b1;
    rob_head_tag = '0;
    cdb_stall = 1'b0;
    for (int i = 0; i < 64; i++) prf_mem[i] = '0;
    for (int i = 0; i < 16; i++) csr_mem[i] = '0;
    prf_mem[3] = 32'hAAAA0000;
    prf_mem[4] = 32'h12345678;
    prf_mem[5] = 32'h0000FFFF;
    csr_mem[5] = 32'h00001234;
    csr_mem[6] = 32'h0000FFFF;
    csr_mem[7] = 32'hF0F0F0F0;
    csr_mem[8] = 32'hDEADBEEF;
    csr_mem[9] = 32'h55AA55AA;

    tick();
    tick();
    sq.push_back('{cyc + 1, 1'b0, 1'b0, 1'b0, 6'd0});
    tick();
    rst = 1'b0;
    tick();

    // CSRRD with write enable set: no CSR write
    rob_head_tag = 6'd1;
    issue(RD, 6'd1, 6'd2, 6'd10, 14'd5, 1'b1, 1'b1, 6'd1, t);
    sq.push_back('{t + 2, 1'b1, 1'b0, 1'b0, 6'd1});
    cq.push_back('{t + 4, 1'b1, 6'd10, 32'h00001234, 6'd1});
    sq.push_back('{t + 4, 1'b1, 1'b0, 1'b1, 6'd1});
    sq.push_back('{t + 5, 1'b0, 1'b0, 1'b0, 6'd0});
    wait_cyc(t + 6);

    // CSRWR
    rob_head_tag = 6'd2;
    issue(WR, 6'd1, 6'd3, 6'd11, 14'd6, 1'b1, 1'b1, 6'd2, t);
    wq.push_back('{t + 3, 14'd6, 32'hAAAA0000});
    cq.push_back('{t + 4, 1'b1, 6'd11, 32'h0000FFFF, 6'd2});
    wait_cyc(t + 6);

    // CSRXCHG with mask
    rob_head_tag = 6'd3;
    issue(XG, 6'd5, 6'd4, 6'd12, 14'd7, 1'b0, 1'b1, 6'd3, t);
    wq.push_back('{t + 3, 14'd7, 32'hF0F05678});
    cq.push_back('{t + 4, 1'b0, 6'd12, 32'hF0F0F0F0, 6'd3});
    wait_cyc(t + 6);

    // unknown encoding acts as a read
    rob_head_tag = 6'd4;
    issue(4'hF, 6'd5, 6'd3, 6'd13, 14'd8, 1'b1, 1'b1, 6'd4, t);
    cq.push_back('{t + 4, 1'b1, 6'd13, 32'hDEADBEEF, 6'd4});
    wait_cyc(t + 6);

    // head mismatch for 5 cycles, then CDB stall for 2
    rob_head_tag = 6'd0;
    issue(WR, 6'd6, 6'd4, 6'd14, 14'd9, 1'b1, 1'b1, 6'd5, t);
    sq.push_back('{t + 7, 1'b1, 1'b0, 1'b0, 6'd6});
    wq.push_back('{t + 8, 14'd9, 32'h12345678});
    for (int k = 9; k <= 11; k++)
      cq.push_back('{t + k, 1'b1, 6'd14, 32'h55AA55AA, 6'd5});
    sq.push_back('{t + 12, 1'b0, 1'b0, 1'b0, 6'd0});
    wait_cyc(t + 7);
    rob_head_tag = 6'd5;
    wait_cyc(t + 8);
    cdb_stall = 1'b1;
    wait_cyc(t + 11);
    cdb_stall = 1'b0;
    wait_cyc(t + 13);

    // flush in WAIT_HEAD
    rob_head_tag = 6'd0;
    issue(XG, 6'd5, 6'd4, 6'd15, 14'd7, 1'b1, 1'b1, 6'd6, t);
    wait_cyc(t + 3);
    flush = 1'b1;
    sq.push_back('{t + 4, 1'b0, 1'b0, 1'b0, 6'd0});
    sq.push_back('{t + 7, 1'b0, 1'b0, 1'b0, 6'd0});
    tick();
    flush = 1'b0;
    rob_head_tag = 6'd6;
    wait_cyc(t + 8);

    // flush in EXEC
    rob_head_tag = 6'd7;
    issue(WR, 6'd1, 6'd3, 6'd16, 14'd6, 1'b1, 1'b1, 6'd7, t);
    wait_cyc(t + 3);
    flush = 1'b1;
    sq.push_back('{t + 4, 1'b0, 1'b0, 1'b0, 6'd0});
    tick();
    flush = 1'b0;
    wait_cyc(t + 7);

    // overrun while waiting for head, then reset
    rob_head_tag = 6'd0;
    issue(RD, 6'd2, 6'd3, 6'd17, 14'd5, 1'b1, 1'b0, 6'd8, t);
    wait_cyc(t + 3);
    ready_awake = 1'b1;
    sq.push_back('{t + 4, 1'b1, 1'b1, 1'b0, 6'd2});
    tick();
    ready_awake = 1'b0;
    wait_cyc(t + 5);
    rst = 1'b1;
    sq.push_back('{t + 6, 1'b0, 1'b0, 1'b0, 6'd0});
    tick();
    rst = 1'b0;
    wait_cyc(t + 8);

    done = 1'b1;
  end

endmodule
